// File: rtl/sine_voice_scheduler.sv
// Shares one external 64-entry sine LUT across NUM_VOICES phase accumulators and
// sums the voices into one signed mix sample per tick. Optional: SINE_SCHED_ATTEN_EN.
module sine_voice_scheduler #(
  parameter int unsigned NUM_VOICES  = 4,
  parameter int unsigned PHASE_W     = 32,
  parameter int unsigned ATTEN_SHIFT = 4,
  localparam int unsigned VID_W      = $clog2(NUM_VOICES),
  localparam int unsigned MIX_W      = 8 + VID_W
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    step_in,
  input  logic                    cfg_valid_in,
  output logic                    cfg_ready_out,
  input  logic [VID_W-1:0]        cfg_voice_in,
  input  logic [PHASE_W-1:0]      cfg_incr_in,
  input  logic                    cfg_enable_in,
  input  logic                    cfg_clr_phase_in,
  output logic [5:0]              lut_phase_out,
  input  logic [7:0]              lut_amp_in,
  output logic signed [MIX_W-1:0] mix_out,
  output logic                    mix_valid_out,
  output logic                    busy_out,
  output logic                    overrun_out
);

  localparam int unsigned IDX_W = VID_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                    r_state;
  logic [PHASE_W-1:0]        r_phase [NUM_VOICES];
  logic [PHASE_W-1:0]        r_incr  [NUM_VOICES];
  logic [NUM_VOICES-1:0]     r_en;
  logic [IDX_W-1:0]          r_idx;
  logic signed [MIX_W-1:0]   r_acc;
  logic signed [MIX_W-1:0]   r_mix;
  logic [5:0]                r_lut_phase;
  logic                      r_mix_valid;
  logic                      r_busy;
  logic                      r_overrun;

  logic                      w_cfg_fire;
  logic                      w_issue;
  logic [VID_W-1:0]          w_iss_vid;
  logic                      w_hit;
  logic [PHASE_W-1:0]        w_base;
  logic                      w_en;
  logic [PHASE_W-1:0]        w_inc;
  logic [VID_W-1:0]          w_samp_vid;
  logic signed [MIX_W-1:0]   w_s;
  logic signed [MIX_W-1:0]   w_contrib;
  logic signed [MIX_W-1:0]   w_sum;

  assign cfg_ready_out = ~r_busy;
  assign lut_phase_out = r_lut_phase;
  assign mix_out       = r_mix;
  assign mix_valid_out = r_mix_valid;
  assign busy_out      = r_busy;
  assign overrun_out   = r_overrun;

  // A config write landing on the same edge as voice 0's issue is forwarded so the frame sees it.
  always_comb begin
    w_cfg_fire = cfg_valid_in & ~r_busy;
    w_issue    = ((r_state == S_IDLE) && step_in) || (r_state == S_ISSUE);
    w_iss_vid  = (r_state == S_ISSUE) ? r_idx[VID_W-1:0] : '0;
    w_hit      = w_cfg_fire && (cfg_voice_in == w_iss_vid);
    w_base     = (w_hit && cfg_clr_phase_in) ? '0 : r_phase[w_iss_vid];
    w_en       = w_hit ? cfg_enable_in : r_en[w_iss_vid];
    w_inc      = w_hit ? cfg_incr_in : r_incr[w_iss_vid];
    w_samp_vid = VID_W'(r_idx - IDX_W'(2));
    w_s        = {{VID_W{~lut_amp_in[7]}}, ~lut_amp_in[7], lut_amp_in[6:0]};
    w_contrib  = r_en[w_samp_vid] ? w_s : '0;
    w_sum      = r_acc + w_contrib;
  end

  // LUT data for the voice issued at edge k arrives at edge k+2.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= S_IDLE;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        r_phase[v] <= '0;
        r_incr[v]  <= '0;
      end
      r_en        <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_mix       <= '0;
      r_lut_phase <= '0;
      r_mix_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_mix_valid <= 1'b0;
      if (step_in && r_busy) r_overrun <= 1'b1;
      if (w_cfg_fire) begin
        r_incr[cfg_voice_in] <= cfg_incr_in;
        r_en[cfg_voice_in]   <= cfg_enable_in;
        if (cfg_clr_phase_in) r_phase[cfg_voice_in] <= '0;
      end
      if (w_issue) begin
        r_lut_phase          <= w_base[PHASE_W-1 -: 6];
        r_phase[w_iss_vid]   <= w_en ? (w_base + w_inc) : w_base;
      end
      case (r_state)
        S_IDLE: begin
          if (step_in) begin
            r_state <= S_ISSUE;
            r_busy  <= 1'b1;
            r_idx   <= IDX_W'(1);
            r_acc   <= '0;
          end
        end
        S_ISSUE: begin
          if (r_idx >= IDX_W'(2)) r_acc <= w_sum;
          r_idx <= r_idx + IDX_W'(1);
          if (r_idx == IDX_W'(NUM_VOICES - 1)) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_idx == IDX_W'(NUM_VOICES)) begin
            r_acc <= w_sum;
            r_idx <= r_idx + IDX_W'(1);
          end else begin
`ifdef SINE_SCHED_ATTEN_EN
            r_mix <= w_sum >>> ATTEN_SHIFT;
`else
            r_mix <= w_sum;
`endif
            r_mix_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Randomized self-checking bench for sine_voice_scheduler with a frame-level voice model.
module tb_sine_voice_scheduler;

  localparam int N     = 4;
  localparam int VID_W = 2;
  localparam int MIX_W = 10;

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b0;
  logic               step_in = 1'b0;
  logic               cfg_valid_in = 1'b0;
  logic               cfg_ready_out;
  logic [VID_W-1:0]   cfg_voice_in = '0;
  logic [31:0]        cfg_incr_in = '0;
  logic               cfg_enable_in = 1'b0;
  logic               cfg_clr_phase_in = 1'b0;
  logic [5:0]         lut_phase_out;
  logic [7:0]         lut_amp_in = 8'd128;
  logic [MIX_W-1:0]   mix_out;
  logic               mix_valid_out;
  logic               busy_out;
  logic               overrun_out;

  sine_voice_scheduler #(.NUM_VOICES(N), .PHASE_W(32), .ATTEN_SHIFT(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .step_in(step_in),
    .cfg_valid_in(cfg_valid_in), .cfg_ready_out(cfg_ready_out),
    .cfg_voice_in(cfg_voice_in), .cfg_incr_in(cfg_incr_in),
    .cfg_enable_in(cfg_enable_in), .cfg_clr_phase_in(cfg_clr_phase_in),
    .lut_phase_out(lut_phase_out), .lut_amp_in(lut_amp_in),
    .mix_out(mix_out), .mix_valid_out(mix_valid_out),
    .busy_out(busy_out), .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  // External sine LUT with a one-cycle registered read.
  logic [7:0] lut_rom [64];
  always @(posedge clk_in) lut_amp_in <= lut_rom[lut_phase_out];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Voice model: what each voice holds, and what one frame should produce.
  int unsigned m_phase [N];
  int unsigned m_incr  [N];
  bit          m_en    [N];
  int          exp_addr [N];
  int          exp_mix;

  task automatic model_reset();
    for (int v = 0; v < N; v++) begin
      m_phase[v] = 0; m_incr[v] = 0; m_en[v] = 0;
    end
  endtask

  task automatic model_cfg(input int vid, input int unsigned inc, input bit en, input bit clr);
    m_incr[vid] = inc;
    m_en[vid]   = en;
    if (clr) m_phase[vid] = 0;
  endtask

  task automatic model_frame();
    int sum;
    sum = 0;
    for (int v = 0; v < N; v++) begin
      exp_addr[v] = int'(m_phase[v] >> 26);
      if (m_en[v]) begin
        sum = sum + int'(lut_rom[exp_addr[v]]) - 128;
        m_phase[v] = m_phase[v] + m_incr[v];
      end
    end
`ifdef SINE_SCHED_ATTEN_EN
    exp_mix = sum >>> 4;
`else
    exp_mix = sum;
`endif
  endtask

  task automatic cfg_write(input int vid, input int unsigned inc, input bit en, input bit clr);
    cfg_valid_in = 1'b1; cfg_voice_in = VID_W'(vid); cfg_incr_in = inc;
    cfg_enable_in = en; cfg_clr_phase_in = clr;
    check("cfg_ready_idle", int'(cfg_ready_out), 1);
    @(posedge clk_in); #1;
    cfg_valid_in = 1'b0; cfg_clr_phase_in = 1'b0;
    model_cfg(vid, inc, en, clr);
  endtask

  task automatic idle_gap(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_in); #1;
      check("no_stray_valid", int'(mix_valid_out), 0);
    end
  endtask

  // One tick: optional simultaneous config write, optional re-tick at edge ovr.
  task automatic frame(input bit do_cfg, input int vid, input int unsigned inc, input bit en,
                       input bit clr, input int ovr, output int got_mix);
    int  n;
    bit  seen;
    if (do_cfg) begin
      cfg_valid_in = 1'b1; cfg_voice_in = VID_W'(vid); cfg_incr_in = inc;
      cfg_enable_in = en; cfg_clr_phase_in = clr;
      model_cfg(vid, inc, en, clr);
    end
    model_frame();
    step_in = 1'b1;
    @(posedge clk_in); #1;
    step_in = 1'b0; cfg_valid_in = 1'b0; cfg_clr_phase_in = 1'b0;
    check("busy_in_frame", int'(busy_out), 1);
    check("ready_in_frame", int'(cfg_ready_out), 0);
    check("addr_v0", int'(lut_phase_out), exp_addr[0]);
    seen = 1'b0; n = -1;
    for (int k = 1; k <= N + 4 && !seen; k++) begin
      step_in = (k == ovr);
      @(posedge clk_in); #1;
      if (k < N) check($sformatf("addr_v%0d", k), int'(lut_phase_out), exp_addr[k]);
      if (k <= N) check("ready_in_frame", int'(cfg_ready_out), 0);
      if (mix_valid_out) begin seen = 1'b1; n = k; end
    end
    step_in = 1'b0;
    check("valid_latency", n, N + 1);
    got_mix = int'($signed(mix_out));
    check("mix_value", got_mix, exp_mix);
    @(posedge clk_in); #1;
    check("valid_one_cycle", int'(mix_valid_out), 0);
    check("busy_after", int'(busy_out), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mix"},     int'($signed(mix_out)), 0);
    check({tag, "_valid"},   int'(mix_valid_out), 0);
    check({tag, "_busy"},    int'(busy_out), 0);
    check({tag, "_overrun"}, int'(overrun_out), 0);
    check({tag, "_addr"},    int'(lut_phase_out), 0);
    check({tag, "_ready"},   int'(cfg_ready_out), 1);
  endtask

  int t2_exp [5] = '{0, 48, 90, 117, 127};
`ifdef SINE_SCHED_ATTEN_EN
  int t3_exp [4] = '{0, 31, 0, -32};
`else
  int t3_exp [4] = '{0, 508, 0, -512};
`endif

  initial begin
    int got;
    for (int i = 0; i < 64; i++)
      lut_rom[i] = 8'($rtoi($floor(127.5 + 127.5 * $sin(2.0 * 3.141592653589793 * real'(i) / 64.0) + 0.5)));
    model_reset();

    // Reset state, during and after reset.
    repeat (3) @(posedge clk_in);
    #1;
    check_reset_outputs("rst_held");
    rst_in = 1'b1;
    idle_gap(2);
    check_reset_outputs("rst_idle");

    // Voice 0 alone, addresses stepping by 4.
    cfg_write(0, 32'h1000_0000, 1'b1, 1'b0);
    for (int t = 0; t < 5; t++) begin
      frame(1'b0, 0, 0, 1'b0, 1'b0, -1, got);
      check("v0_sine", got, t2_exp[t]);
      idle_gap(1);
    end

    // All voices in phase, quarter-cycle steps.
    for (int v = 0; v < N; v++) cfg_write(v, 32'h4000_0000, 1'b1, 1'b1);
    for (int t = 0; t < 4; t++) begin
      frame(1'b0, 0, 0, 1'b0, 1'b0, -1, got);
      check("all_voices", got, t3_exp[t]);
      idle_gap(1);
    end

    // Re-tick while busy: single pulse, sticky overrun.
    check("overrun_before", int'(overrun_out), 0);
    frame(1'b0, 0, 0, 1'b0, 1'b0, 2, got);
    idle_gap(6);
    check("overrun_set", int'(overrun_out), 1);
    frame(1'b0, 0, 0, 1'b0, 1'b0, -1, got);
    idle_gap(1);
    check("overrun_sticky", int'(overrun_out), 1);

    // Config clearing/disabling voice 2 at the same edge as the tick.
    frame(1'b1, 2, 32'h0123_4567, 1'b0, 1'b1, -1, got);
    idle_gap(1);
    for (int t = 0; t < 2; t++) begin
      frame(1'b0, 0, 0, 1'b0, 1'b0, -1, got);
      check("v2_phase_held", exp_addr[2], 0);
      idle_gap(1);
    end

    // Reset in the middle of a frame.
    step_in = 1'b1;
    @(posedge clk_in); #1;
    step_in = 1'b0;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    idle_gap(6);
    rst_in = 1'b1;
    model_reset();
    idle_gap(1);
    cfg_write(1, 32'h0800_0000, 1'b1, 1'b0);
    cfg_write(3, 32'h2000_0000, 1'b1, 1'b0);
    for (int t = 0; t < 3; t++) begin
      frame(1'b0, 0, 0, 1'b0, 1'b0, -1, got);
      idle_gap(1);
    end
    check("overrun_cleared", int'(overrun_out), 0);

    // Random configurations and ticks.
    for (int it = 0; it < 30; it++) begin
      int nw;
      nw = int'($urandom_range(0, 2));
      for (int w = 0; w < nw; w++)
        cfg_write(int'($urandom_range(0, N - 1)), $urandom, 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 3) == 0));
      frame(1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)), $urandom,
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), -1, got);
      idle_gap(int'($urandom_range(1, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
